// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencing controller: picks the PC source, generates stall
// and flush controls, and maintains a circular return-address stack.
module fetch_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic              dec_jump,
  input  logic              dec_call,
  input  logic              dec_ret,
  input  logic              dec_branch_taken,
  input  logic [ADDR_W-1:0] dec_link_addr,
  input  logic              load_use_hazard,
  input  logic              ext_stall,
  output logic [1:0]        pc_src,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ras_empty,
  output logic              ras_ovf,
  output logic              ras_unf
);

  // state   | meaning
  // S_RUN   | normal sequential fetch
  // S_STALL | front end frozen by a hazard or fetch wait
  // S_SHADOW| cycle after a redirect; decode slot holds a squashed instruction
  typedef enum logic [1:0] {S_RUN, S_STALL, S_SHADOW} state_e;

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     sp_q, sp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] entry_q [RAS_DEPTH];
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop, ev_valid, ras_full;
  logic [PW-1:0]     sp_m1;

  assign ev_valid = dec_valid && (state_q != S_SHADOW);
  assign ras_full = (cnt_q == CW'(RAS_DEPTH));
  assign sp_m1    = sp_q - PW'(1);

  always_comb begin
    pc_src     = 2'b00;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    state_d    = S_RUN;
    if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      // a stalled shadow keeps masking the squashed decode slot
      state_d    = (state_q == S_SHADOW) ? S_SHADOW : S_STALL;
    end else if (state_q == S_SHADOW) begin
      state_d = S_RUN;
    end else if (ev_valid && load_use_hazard) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_d    = S_STALL;
    end else if (ev_valid && dec_ret) begin
      pc_src     = 2'b11;
      ifid_flush = 1'b1;
      pop        = 1'b1;
      state_d    = S_SHADOW;
    end else if (ev_valid && dec_branch_taken) begin
      pc_src     = 2'b10;
      ifid_flush = 1'b1;
      state_d    = S_SHADOW;
    end else if (ev_valid && (dec_jump || dec_call)) begin
      pc_src     = 2'b01;
      ifid_flush = 1'b1;
      push       = dec_call;
      state_d    = S_SHADOW;
    end
  end

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      sp_d = sp_q + PW'(1);
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        sp_d  = sp_m1;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // when full, sp already points at the oldest entry, so a push overwrites it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) entry_q[i] <= '0;
    end else if (push) begin
      entry_q[sp_q] <= dec_link_addr;
    end
  end

  assign ret_addr  = (cnt_q != '0) ? entry_q[sp_m1] : '0;
  assign ras_empty = (cnt_q == '0);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dec_valid = 1'b0, dec_jump = 1'b0, dec_call = 1'b0, dec_ret = 1'b0;
  logic        dec_branch_taken = 1'b0, load_use_hazard = 1'b0, ext_stall = 1'b0;
  logic [15:0] dec_link_addr = '0;
  logic [1:0]  pc_src;
  logic        pc_write, ifid_write, ifid_flush, ras_empty, ras_ovf, ras_unf;
  logic [15:0] ret_addr;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.ADDR_W(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_jump(dec_jump),
    .dec_call(dec_call), .dec_ret(dec_ret), .dec_branch_taken(dec_branch_taken),
    .dec_link_addr(dec_link_addr), .load_use_hazard(load_use_hazard),
    .ext_stall(ext_stall), .pc_src(pc_src), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ret_addr(ret_addr),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  // drive decode inputs (called just after a falling edge), settle 1 time unit
  task automatic drive(input logic v, input logic j, input logic c, input logic r,
                       input logic b, input logic [15:0] link, input logic lu,
                       input logic es);
    dec_valid = v; dec_jump = j; dec_call = c; dec_ret = r;
    dec_branch_taken = b; dec_link_addr = link; load_use_hazard = lu; ext_stall = es;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_src !== 2'b00 || pc_write !== 1'b1 || ifid_write !== 1'b1 ||
        ifid_flush !== 1'b0 || ret_addr !== 16'h0 || ras_empty !== 1'b1 ||
        ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got src=%b pw=%b iw=%b fl=%b ret=%h emp=%b ovf=%b unf=%b",
               pc_src, pc_write, ifid_write, ifid_flush, ret_addr, ras_empty, ras_ovf, ras_unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pc_src !== 2'b00 || pc_write !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got src=%b pw=%b want 00/1", i, pc_src, pc_write);
      end
    end
  endtask

  task automatic test_call_return();
    drive(1, 0, 1, 0, 0, 16'h0010, 0, 0);
    checks++;
    if (pc_src !== 2'b01 || ifid_flush !== 1'b1) begin
      errors++;
      $display("FAIL call1: got src=%b fl=%b want 01/1", pc_src, ifid_flush);
    end
    tick(); idle(); tick();
    drive(1, 0, 1, 0, 0, 16'h0020, 0, 0);
    checks++;
    if (pc_src !== 2'b01 || ifid_flush !== 1'b1) begin
      errors++;
      $display("FAIL call2: got src=%b fl=%b want 01/1", pc_src, ifid_flush);
    end
    tick(); idle(); tick();
    drive(1, 0, 0, 1, 0, 16'h0, 0, 0);
    checks++;
    if (pc_src !== 2'b11 || ifid_flush !== 1'b1 || ret_addr !== 16'h0020) begin
      errors++;
      $display("FAIL ret1: got src=%b fl=%b ret=%h want 11/1/0020", pc_src, ifid_flush, ret_addr);
    end
    tick(); idle(); tick();
    checks++;
    if (ret_addr !== 16'h0010 || ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL ret2_addr: got ret=%h emp=%b want 0010/0", ret_addr, ras_empty);
    end
    drive(1, 0, 0, 1, 0, 16'h0, 0, 0);
    tick(); idle(); tick();
    checks++;
    if (ras_empty !== 1'b1 || ret_addr !== 16'h0) begin
      errors++;
      $display("FAIL ret2_empty: got emp=%b ret=%h want 1/0000", ras_empty, ret_addr);
    end
  endtask

  task automatic test_ovf_unf();
    logic [15:0] exp_pop [4];
    exp_pop[0] = 16'h000A; exp_pop[1] = 16'h0008; exp_pop[2] = 16'h0006; exp_pop[3] = 16'h0004;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 1, 0, 0, 16'(2 * i), 0, 0);
      tick(); idle(); tick();
    end
    checks++;
    if (ras_ovf !== 1'b1 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flag: got ovf=%b unf=%b want 1/0", ras_ovf, ras_unf);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0, 16'h0, 0, 0);
      checks++;
      if (ret_addr !== exp_pop[i] || pc_src !== 2'b11) begin
        errors++;
        $display("FAIL pop[%0d]: got ret=%h src=%b want %h/11", i, ret_addr, pc_src, exp_pop[i]);
      end
      tick(); idle(); tick();
    end
    checks++;
    if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL drained: got emp=%b unf=%b want 1/0", ras_empty, ras_unf);
    end
    drive(1, 0, 0, 1, 0, 16'h0, 0, 0);
    tick(); idle(); tick();
    checks++;
    if (ras_unf !== 1'b1 || ret_addr !== 16'h0 || ras_empty !== 1'b1 || ras_ovf !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got unf=%b ret=%h emp=%b ovf=%b want 1/0000/1/1",
               ras_unf, ret_addr, ras_empty, ras_ovf);
    end
  endtask

  task automatic test_reset_mid_shadow();
    drive(1, 0, 0, 0, 1, 16'h0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 16'h0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_src !== 2'b01 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_shadow: got src=%b ovf=%b unf=%b want 01/0/0", pc_src, ras_ovf, ras_unf);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stall_vs_redirect();
    drive(1, 0, 1, 0, 0, 16'h0030, 0, 0);
    tick(); idle(); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 0, 16'h0, 0, 1);
      checks++;
      if (pc_write !== 1'b0 || ifid_write !== 1'b0 || pc_src !== 2'b00 || ifid_flush !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got pw=%b iw=%b src=%b fl=%b want 0/0/00/0",
                 i, pc_write, ifid_write, pc_src, ifid_flush);
      end
      tick();
      checks++;
      if (ret_addr !== 16'h0030 || ras_empty !== 1'b0) begin
        errors++;
        $display("FAIL stall_nopop[%0d]: got ret=%h emp=%b want 0030/0", i, ret_addr, ras_empty);
      end
    end
    drive(1, 0, 0, 1, 0, 16'h0, 0, 0);
    checks++;
    if (pc_src !== 2'b11 || ifid_flush !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got src=%b fl=%b pw=%b want 11/1/1", pc_src, ifid_flush, pc_write);
    end
    tick(); idle(); tick();
    checks++;
    if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL stall_onepop: got emp=%b unf=%b want 1/0", ras_empty, ras_unf);
    end
  endtask

  task automatic test_priority_shadow();
    drive(1, 1, 0, 0, 1, 16'h0, 0, 0);
    checks++;
    if (pc_src !== 2'b10 || ifid_flush !== 1'b1) begin
      errors++;
      $display("FAIL br_over_jump: got src=%b fl=%b want 10/1", pc_src, ifid_flush);
    end
    tick();
    drive(1, 1, 0, 0, 0, 16'h0, 0, 0);
    checks++;
    if (pc_src !== 2'b00 || ifid_flush !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL shadow_mask: got src=%b fl=%b pw=%b want 00/0/1", pc_src, ifid_flush, pc_write);
    end
    tick(); idle(); tick();
  endtask

  task automatic test_load_use();
    drive(1, 0, 1, 0, 0, 16'h0040, 1, 0);
    checks++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0 || pc_src !== 2'b00 || ifid_flush !== 1'b0) begin
      errors++;
      $display("FAIL lu_hold: got pw=%b iw=%b src=%b fl=%b want 0/0/00/0",
               pc_write, ifid_write, pc_src, ifid_flush);
    end
    tick();
    checks++;
    if (ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL lu_nopush: got emp=%b want 1", ras_empty);
    end
    drive(1, 0, 1, 0, 0, 16'h0040, 0, 0);
    checks++;
    if (pc_src !== 2'b01 || ifid_flush !== 1'b1) begin
      errors++;
      $display("FAIL lu_release: got src=%b fl=%b want 01/1", pc_src, ifid_flush);
    end
    tick(); idle(); tick();
    checks++;
    if (ret_addr !== 16'h0040 || ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL lu_push: got ret=%h emp=%b want 0040/0", ret_addr, ras_empty);
    end
    drive(1, 0, 0, 1, 0, 16'h0, 0, 0);
    tick(); idle(); tick();
    checks++;
    if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL lu_onepush: got emp=%b unf=%b want 1/0", ras_empty, ras_unf);
    end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_ovf_unf();
    test_reset_mid_shadow();
    test_stall_vs_redirect();
    test_priority_shadow();
    test_load_use();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
